coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- Bus-side responder for two snooping data caches (MSI). Sits between both dcaches' cache-side ports and the single-ported RAM.
- Arbitrates cache misses and write-backs, drives snoops (ccwait / ccsnoopaddr / ccinv) into the non-requesting cache, and serves fills either cache-to-cache (dirty holder supplies the block and it is written back to RAM in the same beat) or from RAM.

Parameters:
- BLK_WORDS, 2, words per cache block; sets the beat count of fill and cache-to-cache transfers.
- WORD_W, 32, data/address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- dREN  in  2  per-cache read request (miss fill beat).
- dWEN  in  2  per-cache write request (eviction/flush write-back, or snoop data supply).
- daddr  in  2xWORD_W  per-cache word address.
- dstore  in  2xWORD_W  per-cache write data.
- cctrans  in  2  per-cache coherence transaction flag; also marks a snoop response.
- ccwrite  in  2  per-cache flag: the miss is for a store (needs exclusive).
- dwait  out  2  per-cache stall; 0 for exactly the cycle a beat completes.
- dload  out  2xWORD_W  per-cache read data, valid when that cache's dwait=0.
- ccwait  out  2  snoop request to a cache.
- ccinv  out  2  invalidate-on-snoop to a cache.
- ccsnoopaddr  out  2xWORD_W  snoop address to a cache.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: FREE=00, BUSY=01, ACCESS=10, ERROR=11.

Behaviour:
- Reset: state=IDLE, grant=0, last=1, beat=0. dwait=2'b11, dload=0, ccwait=0, ccinv=0, ccsnoopaddr=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0. Reset asserted in any state aborts the transaction the same edge; no RAM strobe in the following cycle.
- Requester index r = grant; snooped cache s = ~r.
- Arbitration in IDLE:
  - req[i] = dREN[i] | dWEN[i].
  - Round-robin: if both request, grant = ~last; otherwise the single requester. last <= grant on grant.
  - IDLE asserts no dwait=0 and no RAM strobe.
- Transition out of IDLE:
  - dWEN[r] & ~cctrans[r] -> WB (plain write-back).
  - dREN[r] & cctrans[r] -> SNOOP1.
  - dWEN[r] & cctrans[r] (flush write-back) -> WB.
  - Any other request is ignored.
- WB: ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r]. On ramstate==ACCESS: dwait[r]=0, next=IDLE. One word per transaction; the cache re-requests for the next word.
- SNOOP1 (1 cycle): ccwait[s]=1, ccsnoopaddr[s]=daddr[r], ccinv[s]=ccwrite[r]. Next state is SNOOP2.
- SNOOP2 (1 cycle): the same snoop outputs held. Samples the response:
  - cctrans[s] & dWEN[s] -> C2C (holder dirty).
  - Else -> RDRAM.
  - ccwait[s] drops when leaving SNOOP2 except into C2C.
- C2C:
  - ccwait[s]=1.
  - ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
  - dload[r]=dstore[s].
  - On ACCESS: dwait[r]=0 and dwait[s]=0 in the same cycle, beat++.
  - When beat==BLK_WORDS-1 completes -> IDLE, beat=0; otherwise stay in C2C.
- RDRAM:
  - ramREN=1, ramaddr=daddr[r], dload[r]=ramload.
  - On ACCESS: dwait[r]=0, beat++.
  - Last beat -> IDLE, beat=0.
- ramstate BUSY or FREE in any transfer state: hold; outputs stable.
- ramstate ERROR: treated as BUSY.
- ramREN and ramWEN are never both 1.
- The non-granted cache's requests wait (dwait=1) until the transaction ends. It is served no earlier than 1 cycle after return to IDLE.
- Simultaneous requests from both caches to the same block: the loser is snooped first, then served next; no deadlock because the snoop path ignores the loser's dREN.
- The beat counter wraps modulo BLK_WORDS; a width of ceil(log2(BLK_WORDS)) bits, minimum 1.

Test Plan:
- Cache0 dWEN=1, cctrans=0, daddr=0x100, dstore=0xDEADBEEF; RAM ACCESS after 2 BUSY cycles -> ramWEN=1 with 0x100/0xDEADBEEF held 3 cycles; dwait[0]=0 only in cycle 3; back to IDLE.
- Cache1 read miss (dREN=1, cctrans=1, ccwrite=0) at 0x200, cache0 clean -> ccwait[0]=1 for 2 cycles with ccsnoopaddr[0]=0x200 and ccinv[0]=0; then 2 RAM read beats with dload[1]=ramload.
- Cache0 store miss (ccwrite=1) at 0x300, cache1 dirty supplying 0xA,0xB -> ccinv[1]=1; dload[0]=0xA then 0xB; RAM written 0xA,0xB; dwait[0] and dwait[1] low together on each beat.
- Both caches assert dREN from IDLE with last=1 -> cache0 granted first, cache1 next; repeat -> alternation.
- RST high during a C2C beat 1 -> next cycle all outputs at reset values, state IDLE, beat=0.
- ramstate=ERROR for 4 cycles then ACCESS during RDRAM -> outputs stable throughout; beat completes only on ACCESS.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// MSI bus controller: arbitrates two snooping dcaches onto one RAM port,
// snoops the non-requesting cache and serves fills cache-to-cache or from RAM.
module coherence_bus_ctrl #(
    parameter int BLK_WORDS = 2,
    parameter int WORD_W    = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    input  logic [1:0]             cctrans,
    input  logic [1:0]             ccwrite,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] dload,
    output logic [1:0]             ccwait,
    output logic [1:0]             ccinv,
    output logic [1:0][WORD_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);

    localparam int BEAT_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLK_WORDS - 1);
    localparam logic [1:0] RAM_ACCESS = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        SNOOP1 = 3'd2,
        SNOOP2 = 3'd3,
        C2C    = 3'd4,
        RDRAM  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic                r, s, access, gnt_c;
    logic [1:0]          req;

    assign r      = grant_q;
    assign s      = ~grant_q;
    assign access = (ramstate == RAM_ACCESS);
    assign req    = dREN | dWEN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        gnt_c   = (req == 2'b11) ? ~last_q : req[1];
        case (state_q)
            IDLE: begin
                // Requests that are neither a write-back nor a coherent read are dropped without a grant.
                if (req != 2'b00) begin
                    if (dWEN[gnt_c]) begin
                        state_d = WB;
                        grant_d = gnt_c;
                        last_d  = gnt_c;
                    end else if (dREN[gnt_c] && cctrans[gnt_c]) begin
                        state_d = SNOOP1;
                        grant_d = gnt_c;
                        last_d  = gnt_c;
                    end
                end
            end
            WB: begin
                if (access) state_d = IDLE;
            end
            SNOOP1: state_d = SNOOP2;
            SNOOP2: begin
                if (cctrans[s] && dWEN[s]) state_d = C2C;
                else                       state_d = RDRAM;
            end
            C2C, RDRAM: begin
                if (access) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dwait       = 2'b11;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state_q)
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r];
                ramstore = dstore[r];
                if (access) dwait[r] = 1'b0;
            end
            SNOOP1, SNOOP2: begin
                ccwait[s]      = 1'b1;
                ccsnoopaddr[s] = daddr[r];
                ccinv[s]       = ccwrite[r];
            end
            C2C: begin
                // Dirty holder's word goes to the requester and to RAM in the same beat.
                ccwait[s] = 1'b1;
                ramWEN    = 1'b1;
                ramaddr   = daddr[s];
                ramstore  = dstore[s];
                dload[r]  = dstore[s];
                if (access) dwait = 2'b00;
            end
            RDRAM: begin
                ramREN   = 1'b1;
                ramaddr  = daddr[r];
                dload[r] = ramload;
                if (access) dwait[r] = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed plus randomized transactions against a transaction-level model
// of the coherence bus (arbitration history, per-beat expected bus values).
module tb_coherence_bus_ctrl;
    localparam int BW = 2;
    localparam int W  = 32;
    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

    logic              CLK = 1'b0;
    logic              RST;
    logic [1:0]        dREN, dWEN, cctrans, ccwrite;
    logic [1:0][W-1:0] daddr, dstore, dload, ccsnoopaddr;
    logic [1:0]        dwait, ccwait, ccinv;
    logic              ramREN, ramWEN;
    logic [W-1:0]      ramaddr, ramstore, ramload;
    logic [1:0]        ramstate;

    int n_chk  = 0;
    int n_fail = 0;
    int last_m = 1;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl #(.BLK_WORDS(BW), .WORD_W(W)) dut (
        .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait),
        .dload(dload), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_in();
        dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    endtask

    function automatic logic [1:0] only_low(input int c);
        logic [1:0] v;
        v = 2'b11;
        v[c] = 1'b0;
        return v;
    endfunction

    function automatic logic [1:0] one_hot(input int c);
        logic [1:0] v;
        v = 2'b00;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, "_dwait"}, dwait, 2'b11);
        chk({tag, "_strobes"}, {ramREN, ramWEN}, 2'b00);
        chk({tag, "_cc"}, {ccwait, ccinv}, 4'b0);
        chk({tag, "_ramaddr"}, ramaddr, 0);
        chk({tag, "_dload"}, dload, 0);
    endtask

    // Single-word write-back from cache c; flush marks a coherent write-back.
    task automatic do_wb(input int c, input logic [W-1:0] a, input logic [W-1:0] d,
                         input int nbusy, input logic [1:0] hs, input logic flush);
        clr_in();
        dWEN[c] = 1'b1; cctrans[c] = flush; daddr[c] = a; dstore[c] = d;
        chk_idle("wb_idle");
        last_m = c;
        for (int i = 0; i <= nbusy; i++) begin
            nxt();
            ramstate = (i == nbusy) ? ACCESS : hs;
            #1;
            chk("wb_wen", {ramREN, ramWEN}, 2'b01);
            chk("wb_addr", ramaddr, a);
            chk("wb_data", ramstore, d);
            chk("wb_dwait", dwait, (i == nbusy) ? only_low(c) : 2'b11);
        end
        nxt();
        clr_in();
        chk_idle("wb_done");
    endtask

    // Coherent miss from cache c. dirty: the other cache supplies the block.
    // other_rd: the other cache also requests throughout (loses arbitration).
    // abort: reset is asserted at the start of beat 1.
    task automatic do_read(input int c, input logic [W-1:0] a, input logic wr,
                           input logic dirty, input logic other_rd, input int nbusy,
                           input logic [1:0] hs, input logic abort);
        int s;
        logic [W-1:0] blk [BW];
        s = 1 - c;
        for (int b = 0; b < BW; b++) blk[b] = $urandom;
        clr_in();
        dREN[c] = 1'b1; cctrans[c] = 1'b1; ccwrite[c] = wr; daddr[c] = a;
        if (other_rd) begin
            dREN[s] = 1'b1; cctrans[s] = 1'b1; daddr[s] = a ^ 32'h40;
        end
        chk_idle("rd_idle");
        last_m = c;
        for (int i = 0; i < 2; i++) begin
            nxt();
            if (i == 1 && dirty) begin
                dREN[s] = 1'b0; dWEN[s] = 1'b1; cctrans[s] = 1'b1;
                daddr[s] = a; dstore[s] = blk[0];
            end
            #1;
            chk("snp_ccwait", ccwait, one_hot(s));
            chk("snp_addr", ccsnoopaddr[s], a);
            chk("snp_inv", ccinv, wr ? one_hot(s) : 2'b00);
            chk("snp_ram", {ramREN, ramWEN}, 2'b00);
            chk("snp_dwait", dwait, 2'b11);
        end
        for (int b = 0; b < BW; b++) begin
            for (int i = 0; i <= nbusy; i++) begin
                nxt();
                if (abort && b == 1) begin
                    RST = 1'b1;
                    nxt();
                    clr_in();
                    chk_idle("rst_abort");
                    RST = 1'b0;
                    last_m = 1;
                    nxt();
                    chk_idle("rst_after");
                    return;
                end
                daddr[c] = a + b;
                ramstate = (i == nbusy) ? ACCESS : hs;
                if (dirty) begin
                    daddr[s] = a + b; dstore[s] = blk[b];
                end else begin
                    ramload = blk[b];
                end
                #1;
                chk("xfer_addr", ramaddr, a + b);
                chk("xfer_dload", dload[c], blk[b]);
                if (dirty) begin
                    chk("c2c_ccwait", ccwait, one_hot(s));
                    chk("c2c_strobe", {ramREN, ramWEN}, 2'b01);
                    chk("c2c_store", ramstore, blk[b]);
                    chk("c2c_dwait", dwait, (i == nbusy) ? 2'b00 : 2'b11);
                end else begin
                    chk("rd_ccwait", ccwait, 2'b00);
                    chk("rd_strobe", {ramREN, ramWEN}, 2'b10);
                    chk("rd_dwait", dwait, (i == nbusy) ? only_low(c) : 2'b11);
                end
            end
        end
        nxt();
        clr_in();
        chk_idle("rd_done");
    endtask

    initial begin
        logic [1:0] hs;
        int         kind, c;
        RST = 1'b1;
        clr_in();
        nxt();
        nxt();
        chk_idle("reset");
        RST = 1'b0;
        nxt();

        do_wb(0, 32'h100, 32'hDEADBEEF, 2, BUSY, 1'b0);
        do_read(1, 32'h200, 1'b0, 1'b0, 1'b0, 0, BUSY, 1'b0);
        do_read(0, 32'h300, 1'b1, 1'b1, 1'b0, 1, BUSY, 1'b0);

        // Both caches request every time: model predicts the winner from history.
        repeat (4) do_read(1 - last_m, 32'h400, 1'b0, 1'b0, 1'b1, 0, FREE, 1'b0);

        do_read(0, 32'h500, 1'b1, 1'b1, 1'b0, 1, BUSY, 1'b1);
        // After reset last=1, so a tie goes to cache 0 again.
        do_read(1 - last_m, 32'h540, 1'b0, 1'b0, 1'b1, 0, FREE, 1'b0);
        do_read(1, 32'h600, 1'b0, 1'b0, 1'b0, 4, ERROR, 1'b0);

        clr_in();
        dREN[0] = 1'b1;
        chk_idle("ignored_a");
        nxt();
        chk_idle("ignored_b");
        do_wb(1, 32'h700, 32'h12345678, 1, FREE, 1'b1);

        repeat (25) begin
            kind = $urandom_range(0, 2);
            c    = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       hs = FREE;
                1:       hs = BUSY;
                default: hs = ERROR;
            endcase
            if (kind == 0)
                do_wb(c, $urandom, $urandom, $urandom_range(0, 3), hs, 1'($urandom_range(0, 1)));
            else
                do_read(c, $urandom & 32'hFFFF_FFF0, 1'($urandom_range(0, 1)), kind == 2,
                        1'b0, $urandom_range(0, 3), hs, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
